// File: rtl/osd_format_pkg.sv
// Shared OSD formatting helpers: format modes, FSM states, ASCII conversion
// and the decimal field-length calculation.
package osd_format_pkg;

  typedef enum logic [1:0] {
    FMT_HEX  = 2'b00,
    FMT_BIN  = 2'b01,
    FMT_DEC  = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_EMIT,
    ST_DONE
  } fmt_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  // ceil(w*log10(2)) digits cover 2^w-1; one extra digit keeps a leading-zero margin
  function automatic int dec_digits_for_width(input int w);
    return (w * 30103 + 99999) / 100000 + 1;
  endfunction

  function automatic logic [7:0] bcd2ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex2ascii(input logic [3:0] d, input logic upper);
    if (d < 4'd10) return bcd2ascii(d);
    return (upper ? 8'h41 : 8'h61) + {4'h0, d} - 8'd10;
  endfunction

endpackage

// File: rtl/osd_num_formatter_if.sv
// Request side and character stream of the OSD number formatter.
interface osd_num_formatter_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] value;
  logic [1:0]       mode;
  logic             blank;
  logic             busy;
  logic [7:0]       ch;
  logic             ch_valid;
  logic             ch_ready;
  logic             ch_last;
  logic             done;

  modport master (
    output start, value, mode, blank, ch_ready,
    input  busy, ch, ch_valid, ch_last, done
  );

  modport slave (
    input  start, value, mode, blank, ch_ready,
    output busy, ch, ch_valid, ch_last, done
  );
endinterface

// File: rtl/osd_bcd_shift.sv
// Iterative double-dabble: one value bit per step, MSB first, done after WIDTH steps.
module osd_bcd_shift
  import osd_format_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = dec_digits_for_width(WIDTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                step,
  input  logic [WIDTH-1:0]    value,
  output logic [DIGITS*4-1:0] bcd,
  output logic                done
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    shreg;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS*4-1:0] adj;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= value;
      bcd   <= '0;
      cnt   <= '0;
    end else if (step && !done) begin
      bcd   <= {adj[DIGITS*4-2:0], shreg[WIDTH-1]};
      shreg <= shreg << 1;
      cnt   <= cnt + 1'b1;
    end
  end

  assign done = (cnt == CNT_W'(WIDTH));

endmodule

// File: rtl/osd_num_formatter.sv
// Formats a WIDTH-bit value as a fixed-length hex, binary or decimal ASCII
// string, one character per valid/ready transfer, most significant digit first.
module osd_num_formatter
  import osd_format_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int UPPERCASE  = 1,
  parameter int DEC_DIGITS = dec_digits_for_width(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  osd_num_formatter_if.slave bus
);
  localparam int HEX_DIGITS = (WIDTH + 3) / 4;
  localparam int BUF_DIGITS = (WIDTH > DEC_DIGITS) ? WIDTH : DEC_DIGITS;
  localparam int POS_W      = $clog2(BUF_DIGITS + 1);

  fmt_state_e state, state_next;
  fmt_mode_e  mode_q, mode_in;
  logic       blank_q;
  logic       seen;
  logic [POS_W-1:0]        pos, pos_init;
  logic [BUF_DIGITS*4-1:0] digits, hex_load, bin_load, dec_load;
  logic [HEX_DIGITS*4-1:0] hex_pad;
  logic [DEC_DIGITS*4-1:0] bcd;
  logic       bcd_done;
  logic       accept, xfer, is_last, dec_step;
  logic [3:0] cur_digit;
  logic [7:0] cur_char;

  assign accept    = (state == ST_IDLE) && bus.start;
  assign xfer      = (state == ST_EMIT) && bus.ch_ready;
  assign is_last   = (pos == '0);
  assign dec_step  = (state == ST_CONV) && (mode_q == FMT_DEC);
  assign cur_digit = 4'(digits >> {pos, 2'b00});

  osd_bcd_shift #(.WIDTH(WIDTH), .DIGITS(DEC_DIGITS)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .step  (dec_step),
    .value (bus.value),
    .bcd   (bcd),
    .done  (bcd_done)
  );

  // The reserved mode code formats as hex; pos counts down to the last character
  always_comb begin
    mode_in = fmt_mode_e'(bus.mode);
    if (mode_in == FMT_RSVD) mode_in = FMT_HEX;
    case (mode_in)
      FMT_BIN: pos_init = POS_W'(WIDTH - 1);
      FMT_DEC: pos_init = POS_W'(DEC_DIGITS - 1);
      default: pos_init = POS_W'(HEX_DIGITS - 1);
    endcase
  end

  always_comb begin
    hex_pad = '0;
    hex_pad[WIDTH-1:0] = bus.value;
    hex_load = '0;
    for (int i = 0; i < HEX_DIGITS; i++) hex_load[4*i +: 4] = hex_pad[4*i +: 4];
    bin_load = '0;
    for (int i = 0; i < WIDTH; i++) bin_load[4*i] = bus.value[i];
    dec_load = '0;
    dec_load[DEC_DIGITS*4-1:0] = bcd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Hex and binary pass through CONV for one cycle so every mode shares the load-to-emit path
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_CONV;
      ST_CONV: if (mode_q != FMT_DEC || bcd_done) state_next = ST_EMIT;
      ST_EMIT: if (xfer && is_last) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= FMT_HEX;
      blank_q <= 1'b0;
      pos     <= '0;
      seen    <= 1'b0;
      digits  <= '0;
    end else if (accept) begin
      mode_q  <= mode_in;
      blank_q <= bus.blank;
      pos     <= pos_init;
      seen    <= 1'b0;
      digits  <= (mode_in == FMT_BIN) ? bin_load : hex_load;
    end else if (dec_step && bcd_done) begin
      digits <= dec_load;
    end else if (xfer) begin
      seen <= seen | (cur_digit != 4'd0);
      if (!is_last) pos <= pos - 1'b1;
    end
  end

  // A zero is blanked only while every earlier digit was zero and it is not the final position
  always_comb begin
    if (blank_q && !seen && cur_digit == 4'd0 && !is_last) cur_char = ASCII_SPACE;
    else if (mode_q == FMT_DEC)                            cur_char = bcd2ascii(cur_digit);
    else                                                   cur_char = hex2ascii(cur_digit, UPPERCASE != 0);
  end

  always_comb begin
    bus.busy     = (state == ST_CONV) || (state == ST_EMIT);
    bus.ch_valid = (state == ST_EMIT);
    bus.ch_last  = (state == ST_EMIT) && is_last;
    bus.done     = (state == ST_DONE);
    bus.ch       = (state == ST_EMIT) ? cur_char : 8'h00;
  end

endmodule

// File: tb/tb_osd_num_formatter.sv
// Scoreboard bench: an upper-case and a lower-case formatter share one stimulus
// stream; expected characters are queued at issue and popped by a monitor.
module tb_osd_num_formatter;
  import osd_format_pkg::*;

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  osd_num_formatter_if #(.WIDTH(16)) bus_a ();
  osd_num_formatter_if #(.WIDTH(16)) bus_b ();

  assign bus_b.start    = bus_a.start;
  assign bus_b.value    = bus_a.value;
  assign bus_b.mode     = bus_a.mode;
  assign bus_b.blank    = bus_a.blank;
  assign bus_b.ch_ready = bus_a.ch_ready;

  osd_num_formatter #(.WIDTH(16), .UPPERCASE(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  osd_num_formatter #(.WIDTH(16), .UPPERCASE(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic       bp_en    = 1'b0;
  logic [3:0] bp_pat   = 4'b1001;
  int         bp_idx   = 0;
  logic       stall_a  = 1'b0;
  logic       stall_b  = 1'b0;
  logic [7:0] stall_ch_a, stall_ch_b;

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Ready changes just after the rising edge so the monitor sees the value the DUT will sample
  task automatic ready_driver();
    bus_a.ch_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) begin
        bus_a.ch_ready = bp_pat[bp_idx[1:0]];
        bp_idx++;
      end else begin
        bus_a.ch_ready = 1'b1;
      end
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_a = 1'b0;
        stall_b = 1'b0;
      end else begin
        if (stall_a) begin
          compare("hold_valid_a", bus_a.ch_valid, 1);
          compare("hold_ch_a", bus_a.ch, stall_ch_a);
        end
        if (stall_b) begin
          compare("hold_valid_b", bus_b.ch_valid, 1);
          compare("hold_ch_b", bus_b.ch, stall_ch_b);
        end
        if (bus_a.ch_valid && bus_a.ch_ready) begin
          if (exp_a.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_ch_a: got 0x%0h, required no character", bus_a.ch);
          end else begin
            e = exp_a.pop_front();
            compare("ch_a", bus_a.ch, e.ch);
            compare("ch_last_a", bus_a.ch_last, e.last);
          end
        end
        if (bus_b.ch_valid && bus_b.ch_ready) begin
          if (exp_b.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_ch_b: got 0x%0h, required no character", bus_b.ch);
          end else begin
            e = exp_b.pop_front();
            compare("ch_b", bus_b.ch, e.ch);
            compare("ch_last_b", bus_b.ch_last, e.last);
          end
        end
        if (bus_a.done) compare("done_after_last_a", exp_a.size(), 0);
        stall_a    = bus_a.ch_valid && !bus_a.ch_ready;
        stall_b    = bus_b.ch_valid && !bus_b.ch_ready;
        stall_ch_a = bus_a.ch;
        stall_ch_b = bus_b.ch;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge where the first character is valid
  task automatic apply_stimulus(input logic [15:0] v, input logic [1:0] m, input logic b,
                                input string s, input int exp_lat);
    exp_t e;
    byte  c;
    int   lat;
    for (int i = 0; i < s.len(); i++) begin
      c      = s[i];
      e.ch   = c;
      e.last = (i == s.len() - 1);
      exp_a.push_back(e);
      if (c >= 8'h41 && c <= 8'h46) c = c + 8'h20;
      e.ch = c;
      exp_b.push_back(e);
    end
    bus_a.start = 1'b1;
    bus_a.value = v;
    bus_a.mode  = m;
    bus_a.blank = b;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    compare("busy_after_start", bus_a.busy, 1);
    lat = 0;
    while (!bus_a.ch_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    compare("first_valid_latency", lat, exp_lat);
  endtask

  task automatic check_output(input int exp_cycles);
    int n;
    n = 0;
    while (!bus_a.done && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    compare("done_seen", bus_a.done, 1);
    if (exp_cycles >= 0) compare("cycles_to_done", n, exp_cycles);
    compare("queue_a_drained", exp_a.size(), 0);
    compare("queue_b_drained", exp_b.size(), 0);
  endtask

  initial begin
    string bin5;
    logic  saw_done;

    bus_a.start = 1'b0;
    bus_a.value = '0;
    bus_a.mode  = 2'b00;
    bus_a.blank = 1'b0;
    fork
      ready_driver();
      monitor_loop();
    join_none

    #2;
    compare("reset_busy", bus_a.busy, 0);
    compare("reset_ch_valid", bus_a.ch_valid, 0);
    compare("reset_ch", bus_a.ch, 0);
    compare("reset_ch_last", bus_a.ch_last, 0);
    compare("reset_done", bus_a.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(16'hBEEF, 2'b00, 1'b0, "BEEF", 1);
    check_output(4);
    @(negedge clk);
    apply_stimulus(16'h00A0, 2'b11, 1'b0, "00A0", 1);
    check_output(4);
    @(negedge clk);
    apply_stimulus(16'd65535, 2'b10, 1'b1, " 65535", 17);
    check_output(6);
    @(negedge clk);
    apply_stimulus(16'd65535, 2'b10, 1'b0, "065535", 17);
    check_output(6);
    @(negedge clk);
    apply_stimulus(16'd0, 2'b10, 1'b1, "     0", 17);
    check_output(6);
    @(negedge clk);
    apply_stimulus(16'd1234, 2'b10, 1'b1, "  1234", 17);
    check_output(6);
    @(negedge clk);
    bin5 = "";
    for (int i = 0; i < 13; i++) bin5 = {bin5, " "};
    bin5 = {bin5, "101"};
    apply_stimulus(16'h0005, 2'b01, 1'b1, bin5, 1);
    check_output(16);
    @(negedge clk);
    apply_stimulus(16'hA5A5, 2'b01, 1'b0, "1010010110100101", 1);
    check_output(16);
    @(negedge clk);

    bp_en = 1'b1;
    apply_stimulus(16'h1234, 2'b00, 1'b0, "1234", 1);
    check_output(-1);
    @(negedge clk);

    apply_stimulus(16'h4321, 2'b00, 1'b0, "4321", 1);
    bus_a.start = 1'b1;
    bus_a.value = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    check_output(-1);
    bp_en = 1'b0;
    bus_a.start = 1'b1;
    bus_a.value = 16'h9999;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    compare("start_in_done_ignored_busy", bus_a.busy, 0);
    compare("start_in_done_ignored_valid", bus_a.ch_valid, 0);
    apply_stimulus(16'h5678, 2'b00, 1'b0, "5678", 1);
    check_output(4);
    @(negedge clk);

    bus_a.start = 1'b1;
    bus_a.value = 16'd12345;
    bus_a.mode  = 2'b10;
    bus_a.blank = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    compare("busy_in_conv", bus_a.busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    compare("abort_busy", bus_a.busy, 0);
    compare("abort_ch_valid", bus_a.ch_valid, 0);
    compare("abort_done", bus_a.done, 0);
    compare("abort_busy_b", bus_b.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus_a.done || bus_a.ch_valid) saw_done = 1'b1;
    end
    compare("no_output_after_abort", saw_done, 0);
    apply_stimulus(16'h00A0, 2'b00, 1'b1, "  A0", 1);
    check_output(4);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
